// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-side memory arbiter.
package mem_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned MEM_SIZE   = 262144;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
  } mem_req_t;

  typedef struct packed {
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } mem_rsp_t;

  // Builds the response for one port; rdata is zero for stores and errors.
  function automatic mem_rsp_t make_rsp(input logic                  hit,
                                        input logic                  we,
                                        input logic                  in_range,
                                        input logic [DATA_WIDTH-1:0] rd_data);
    mem_rsp_t rsp;
    rsp        = '0;
    rsp.rvalid = hit;
    rsp.err    = hit & ~in_range;
    rsp.rdata  = (hit && !we && in_range) ? rd_data : '0;
    return rsp;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker with an m1 burst lock; purely combinational.
// DATA_MEM_ARB_FIXED_PRIO_EN selects fixed priority (m0 always wins).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       lock,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = lock ^ last_grant;

  always_comb begin
    grant = 2'b00;
    if (req[0])      grant = 2'b01;
    else if (req[1]) grant = 2'b10;
  end
`else
  // Lock only holds once m1 already owns the port.
  always_comb begin
    grant = 2'b00;
    if (lock && last_grant && req[1]) grant = 2'b10;
    else if (req == 2'b11)            grant = last_grant ? 2'b01 : 2'b10;
    else                              grant = req;
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares memory read port 2 and the write port between the LSU (m0) and loader/debug (m1).
// Build option DATA_MEM_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin with lock.
module data_mem_arbiter
  import mem_pkg::mem_req_t;
  import mem_pkg::mem_rsp_t;
  import mem_pkg::make_rsp;
#(
  parameter  int unsigned ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH = mem_pkg::DATA_WIDTH,
  parameter  int unsigned MEM_SIZE   = mem_pkg::MEM_SIZE,
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [BE_WIDTH-1:0]   m0_be,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,

  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [BE_WIDTH-1:0]   m1_be,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  input  logic                  m1_lock,

  output logic [ADDR_WIDTH-1:0] mem_addr2,
  input  logic [DATA_WIDTH-1:0] mem_rd_data2,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [BE_WIDTH-1:0]   mem_byte_en
);

  logic [1:0] req;
  logic [1:0] grant;
  logic       granted;
  logic       in_range;
  logic       last_grant;
  mem_req_t   win;
  mem_rsp_t   rsp0_q;
  mem_rsp_t   rsp1_q;

  assign req = {m1_valid, m0_valid};

  rr_arb2 u_arb (
    .req        (req),
    .lock       (m1_lock),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Winner payload mux; idle drives zeros.
  always_comb begin
    win = '0;
    if (grant[1])      win = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, be: m1_be};
    else if (grant[0]) win = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, be: m0_be};
  end

  assign granted  = |grant;
  // Extra bit keeps MEM_SIZE-4 comparison from wrapping at the top of the address space.
  assign in_range = {1'b0, win.addr} <= (ADDR_WIDTH+1)'(MEM_SIZE - 4);

  assign m0_ready    = grant[0] & rst_n;
  assign m1_ready    = grant[1] & rst_n;
  assign mem_addr2   = win.addr;
  assign mem_wr_addr = win.addr;
  assign mem_wr_data = win.wdata;
  assign mem_byte_en = win.be;
  assign mem_wr_en   = granted & win.we & in_range & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      rsp0_q     <= '0;
      rsp1_q     <= '0;
    end else begin
      if (granted) last_grant <= grant[1];
      rsp0_q <= make_rsp(grant[0], win.we, in_range, mem_rd_data2);
      rsp1_q <= make_rsp(grant[1], win.we, in_range, mem_rd_data2);
    end
  end

  assign m0_rvalid = rsp0_q.rvalid;
  assign m0_rdata  = rsp0_q.rdata;
  assign m0_err    = rsp0_q.err;
  assign m1_rvalid = rsp1_q.rvalid;
  assign m1_rdata  = rsp1_q.rdata;
  assign m1_err    = rsp1_q.err;

  // A pending request must stay valid until it is granted.
  a_m0_hold: assert property (@(posedge clk) disable iff (!rst_n)
                              (rst_n && m0_valid && !m0_ready) |=> m0_valid);
  a_m1_hold: assert property (@(posedge clk) disable iff (!rst_n)
                              (rst_n && m1_valid && !m1_ready) |=> m1_valid);

endmodule
